// File: rtl/scalar_wb_pkg.sv
// Shared constants and the queued write-back entry type for the scalar write-back unit.
package scalar_wb_pkg;

    localparam int WB_REG_SIZE = 32;
    localparam int WB_REG_QTY  = 4;
    localparam int WB_SEL_BITS = 2;
    localparam int WB_DEPTH    = 4;
    localparam int WB_PTR_W    = $clog2(WB_DEPTH);

    typedef struct packed {
        logic [WB_SEL_BITS-1:0] idx;
        logic [WB_REG_SIZE-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO holding pending register writes; head entry is exposed combinationally.
module wb_fifo
    import scalar_wb_pkg::*;
#(
    parameter int WIDTH = $bits(wb_entry_t),
    parameter int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: storage needs no reset; the pointers and count alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/scalar_wb_unit.sv
// Write-side front end of the scalar register file: ALU/memory arbitration, in-order
// write-back FIFO, and a per-register pending scoreboard for decode-stage stalls.
module scalar_wb_unit
    import scalar_wb_pkg::*;
#(
    parameter int regSize     = WB_REG_SIZE,
    parameter int regQuantity = WB_REG_QTY,
    parameter int selBits     = WB_SEL_BITS,
    parameter int depth       = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   aluValid,
    output logic                   aluReady,
    input  logic [selBits-1:0]     aluReg,
    input  logic [regSize-1:0]     aluData,
    input  logic                   memValid,
    output logic                   memReady,
    input  logic [selBits-1:0]     memReg,
    input  logic [regSize-1:0]     memData,
    input  logic                   wbStall,
    output logic                   regWrEn,
    output logic [selBits-1:0]     regToWrite,
    output logic [regSize-1:0]     dataIn,
    output logic [regQuantity-1:0] pendingMask,
    output logic                   fifoEmpty
);

    localparam int PTR_W   = $clog2(depth);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = selBits + regSize;

    logic               full, empty, push, pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] push_entry, head;
    logic [selBits-1:0] push_idx, head_idx;
    logic [regSize-1:0] head_data;

    logic [CNT_W-1:0]       cnt_q [regQuantity];
    logic [CNT_W-1:0]       cnt_d [regQuantity];
    logic [regQuantity-1:0] pend_q, pend_d;

    // Readies are forced low during reset; full only looks at current occupancy.
    assign aluReady = reset && !full;
    assign memReady = reset && !full && !aluValid;

    assign push       = (aluValid && aluReady) || (memValid && memReady);
    assign push_idx   = aluValid ? aluReg : memReg;
    assign push_entry = aluValid ? {aluReg, aluData} : {memReg, memData};

    assign head_idx  = head[ENTRY_W-1 -: selBits];
    assign head_data = head[regSize-1:0];

    assign pop        = !empty && !wbStall;
    assign regWrEn    = pop;
    assign regToWrite = empty ? '0 : head_idx;
    assign dataIn     = empty ? '0 : head_data;
    assign fifoEmpty  = (fifo_count == '0);
    assign pendingMask = pend_q;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (depth)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (fifo_count),
        .head_o      (head)
    );

    // NOTE: next-state logic uses blocking assignments with a default first, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < regQuantity; i++) begin
            cnt_d[i] = cnt_q[i];
            case ({push && (push_idx == selBits'(i)), pop && (head_idx == selBits'(i))})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
            pend_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < regQuantity; i++) begin
                cnt_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < regQuantity; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_scalar_wb_unit.sv
// Directed self-checking bench for scalar_wb_unit with hand-computed expectations.
module tb_scalar_wb_unit;
    import scalar_wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        aluValid, aluReady, memValid, memReady, wbStall;
    logic [1:0]  aluReg, memReg, regToWrite;
    logic [31:0] aluData, memData, dataIn;
    logic        regWrEn, fifoEmpty;
    logic [3:0]  pendingMask;

    int n_checks = 0;
    int n_fail   = 0;

    wb_entry_t ref_q [$];
    wb_entry_t ent;

    scalar_wb_unit dut (
        .clk         (clk),
        .reset       (reset),
        .aluValid    (aluValid),
        .aluReady    (aluReady),
        .aluReg      (aluReg),
        .aluData     (aluData),
        .memValid    (memValid),
        .memReady    (memReady),
        .memReg      (memReg),
        .memData     (memData),
        .wbStall     (wbStall),
        .regWrEn     (regWrEn),
        .regToWrite  (regToWrite),
        .dataIn      (dataIn),
        .pendingMask (pendingMask),
        .fifoEmpty   (fifoEmpty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [1:0] r, input logic [31:0] d);
        check({tag, " wren"}, 64'(regWrEn), 64'd1);
        check({tag, " reg"},  64'(regToWrite), 64'(r));
        check({tag, " data"}, 64'(dataIn), 64'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; aluValid = 1'b0; memValid = 1'b0; wbStall = 1'b0;
        aluReg = '0; memReg = '0; aluData = '0; memData = '0;
        tick();
        tick();
        check("rst wren",    64'(regWrEn), 64'd0);
        check("rst reg",     64'(regToWrite), 64'd0);
        check("rst data",    64'(dataIn), 64'd0);
        check("rst pending", 64'(pendingMask), 64'd0);
        check("rst empty",   64'(fifoEmpty), 64'd1);
        check("rst aluRdy",  64'(aluReady), 64'd0);
        check("rst memRdy",  64'(memReady), 64'd0);
        reset = 1'b1;

        // Single ALU write to reg 2
        aluValid = 1'b1; aluReg = 2'd2; aluData = 32'hDEADBEEF;
        #1;
        check("t1 aluRdy", 64'(aluReady), 64'd1);
        tick();
        aluValid = 1'b0;
        #1;
        expect_write("t1 wr", 2'd2, 32'hDEADBEEF);
        check("t1 pending", 64'(pendingMask), 64'b0100);
        tick();
        check("t1 pending after", 64'(pendingMask), 64'd0);
        check("t1 empty after",   64'(fifoEmpty), 64'd1);
        check("t1 wren after",    64'(regWrEn), 64'd0);

        // ALU wins over memory, memory follows
        aluValid = 1'b1; aluReg = 2'd1; aluData = 32'h11;
        memValid = 1'b1; memReg = 2'd3; memData = 32'h33;
        #1;
        check("t2 aluRdy", 64'(aluReady), 64'd1);
        check("t2 memRdy", 64'(memReady), 64'd0);
        tick();
        aluValid = 1'b0;
        #1;
        check("t2 memRdy c2", 64'(memReady), 64'd1);
        expect_write("t2 wr1", 2'd1, 32'h11);
        tick();
        memValid = 1'b0;
        #1;
        expect_write("t2 wr2", 2'd3, 32'h33);
        check("t2 pending", 64'(pendingMask), 64'b1000);
        tick();
        check("t2 empty", 64'(fifoEmpty), 64'd1);

        // Fill under stall, fifth offer refused until a slot frees
        wbStall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            aluValid = 1'b1; aluReg = 2'(k); aluData = 32'h100 + k;
            #1;
            check($sformatf("t3 aluRdy %0d", k), 64'(aluReady), 64'd1);
            check($sformatf("t3 stalled %0d", k), 64'(regWrEn), 64'd0);
            tick();
        end
        aluReg = 2'd0; aluData = 32'h104;
        #1;
        check("t3 full aluRdy",  64'(aluReady), 64'd0);
        check("t3 full memRdy",  64'(memReady), 64'd0);
        check("t3 full pending", 64'(pendingMask), 64'b1111);
        check("t3 full empty",   64'(fifoEmpty), 64'd0);
        tick();
        check("t3 still full", 64'(aluReady), 64'd0);
        wbStall = 1'b0;
        #1;
        expect_write("t3 wrA", 2'd0, 32'h100);
        check("t3 A aluRdy",  64'(aluReady), 64'd0);
        check("t3 A pending", 64'(pendingMask), 64'b1111);
        tick();
        expect_write("t3 wrB", 2'd1, 32'h101);
        check("t3 B aluRdy",  64'(aluReady), 64'd1);
        check("t3 B pending", 64'(pendingMask), 64'b1110);
        tick();
        aluValid = 1'b0;
        #1;
        expect_write("t3 wrC", 2'd2, 32'h102);
        check("t3 C pending", 64'(pendingMask), 64'b1101);
        tick();
        expect_write("t3 wrD", 2'd3, 32'h103);
        check("t3 D pending", 64'(pendingMask), 64'b1001);
        tick();
        expect_write("t3 wrE", 2'd0, 32'h104);
        check("t3 E pending", 64'(pendingMask), 64'b0001);
        tick();
        check("t3 empty", 64'(fifoEmpty), 64'd1);

        // Two writes to the same register stay ordered
        wbStall = 1'b1;
        aluValid = 1'b1; aluReg = 2'd0; aluData = 32'hA;
        tick();
        aluData = 32'hB;
        tick();
        aluValid = 1'b0;
        #1;
        check("t4 pending stalled", 64'(pendingMask), 64'b0001);
        wbStall = 1'b0;
        #1;
        expect_write("t4 wrA", 2'd0, 32'hA);
        tick();
        expect_write("t4 wrB", 2'd0, 32'hB);
        check("t4 pending mid", 64'(pendingMask), 64'b0001);
        tick();
        check("t4 pending done", 64'(pendingMask), 64'd0);
        check("t4 empty",        64'(fifoEmpty), 64'd1);

        // Back-to-back streaming against a reference queue; pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            aluValid = 1'b1; aluReg = 2'(i); aluData = 32'h5000 + i;
            #1;
            if (i > 0) begin
                expect_write($sformatf("t5 wr %0d", i), ref_q[0].idx, ref_q[0].data);
                check($sformatf("t5 pending %0d", i), 64'(pendingMask), 64'(4'b0001 << ref_q[0].idx));
                check($sformatf("t5 nonempty %0d", i), 64'(fifoEmpty), 64'd0);
            end
            check($sformatf("t5 aluRdy %0d", i), 64'(aluReady), 64'd1);
            ent.idx = aluReg; ent.data = aluData;
            tick();
            if (i > 0) void'(ref_q.pop_front());
            ref_q.push_back(ent);
        end
        aluValid = 1'b0;
        #1;
        expect_write("t5 last", ref_q[0].idx, ref_q[0].data);
        tick();
        void'(ref_q.pop_front());
        check("t5 empty", 64'(fifoEmpty), 64'd1);

        // Asynchronous reset with three entries queued
        wbStall = 1'b1;
        for (int k = 1; k < 4; k++) begin
            aluValid = 1'b1; aluReg = 2'(k); aluData = 32'h700 + k;
            tick();
        end
        aluValid = 1'b0;
        wbStall = 1'b0;
        #1;
        expect_write("t6 pre", 2'd1, 32'h701);
        reset = 1'b0;
        #1;
        check("t6 rst wren",    64'(regWrEn), 64'd0);
        check("t6 rst pending", 64'(pendingMask), 64'd0);
        check("t6 rst empty",   64'(fifoEmpty), 64'd1);
        check("t6 rst aluRdy",  64'(aluReady), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t6 rel aluRdy", 64'(aluReady), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t6 no stale wren %0d", k), 64'(regWrEn), 64'd0);
            check($sformatf("t6 no stale empty %0d", k), 64'(fifoEmpty), 64'd1);
            check($sformatf("t6 no stale pend %0d", k), 64'(pendingMask), 64'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scalar_wb_unit.md
Name: scalar_wb_unit

Overview:
- Write-side front end for the scalar register file. Accepts results from two producers, ALU and memory, over valid/ready handshakes.
- Buffers accepted results in a small in-order FIFO and drives the register file's single write port (regWrEn, regToWrite, dataIn), one entry per cycle.
- Exports a per-register pending mask so the decode stage stalls reads of registers with writes still in flight.

Parameters:
- regSize, 32, data width of one register
- regQuantity, 4, number of scalar registers
- selBits, 2, register index width; must satisfy 2**selBits == regQuantity
- depth, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- aluValid  in  1  ALU result valid
- aluReady  out  1  ALU result accepted this cycle
- aluReg  in  selBits  ALU destination register
- aluData  in  regSize  ALU result
- memValid  in  1  memory result valid
- memReady  out  1  memory result accepted this cycle
- memReg  in  selBits  memory destination register
- memData  in  regSize  memory result
- wbStall  in  1  register-file side blocks the dequeue this cycle
- regWrEn  out  1  register file write enable
- regToWrite  out  selBits  register file write index
- dataIn  out  regSize  register file write data
- pendingMask  out  regQuantity  bit i = 1 while any queued entry targets register i
- fifoEmpty  out  1  no entries held

Behaviour:
- Reset (reset low, asynchronous): FIFO pointers = 0, all per-register counters = 0.
  - regWrEn = 0, regToWrite = 0, dataIn = 0, pendingMask = 0, fifoEmpty = 1.
  - aluReady = memReady = 0 while reset is low.
  - Any entries held when reset asserts are discarded; no partial write is issued.
- Enqueue: at most one entry per cycle, fixed priority ALU over memory.
  - aluReady = !full.
  - memReady = !full && !aluValid.
  - Handshake completes on valid && ready at the rising edge; the entry is {reg, data} from the winning port.
  - Producers must hold valid, reg and data stable until accepted.
- full is evaluated on the current occupancy only; a same-cycle dequeue does not free a slot for the enqueue. Full is reached at count == depth.
- Dequeue:
  - Write outputs are combinational from the FIFO head registers only; there is no combinational path from producer inputs.
  - regWrEn = !empty && !wbStall; regToWrite/dataIn = head entry. When empty, regToWrite = 0 and dataIn = 0.
  - The head pops at the edge where regWrEn = 1.
- Latency: a result accepted at edge N into an empty FIFO appears on regWrEn in the cycle following edge N and is written at edge N+1, provided wbStall = 0.
- Order: register writes occur strictly in acceptance order. Two writes to the same register are never reordered.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Wrap-around: pointers are log2(depth) bits and wrap naturally. A separate count of log2(depth)+1 bits distinguishes full from empty.
- Scoreboard:
  - Per-register counter, width log2(depth)+1: increment on enqueue to that register, decrement on dequeue from it.
  - When enqueue and dequeue target the same register in one cycle, the counter is unchanged.
  - pendingMask[i] = (counter[i] != 0), registered, consistent with FIFO contents at every edge.
- wbStall held high indefinitely: the FIFO fills, both ready outputs drop, and no state is lost.
- Counter overflow is impossible by construction (bounded by depth).

Decomposition:
- Package scalar_wb_pkg:
  - typedef wb_entry_t {reg index, data}, sized from package constants matching the default parameters.
  - Constant WB_PTR_W = log2(depth).
- Sub-module wb_fifo: synchronous FIFO with push, pop, full, empty, count and head-entry output, same clk/reset convention.
- Arbitration, output drive and scoreboard live in scalar_wb_unit.

Test Plan:
- Reset release, then aluValid=1, aluReg=2, aluData=0xDEADBEEF for one cycle -> aluReady=1. Next cycle regWrEn=1, regToWrite=2, dataIn=0xDEADBEEF, pendingMask=0100. Following cycle pendingMask=0000, fifoEmpty=1.
- aluValid and memValid both high (aluReg=1/0x11, memReg=3/0x33) -> cycle 1: aluReady=1, memReady=0. Cycle 2: memReady=1. Writes appear as reg1=0x11, then reg3=0x33 on consecutive cycles.
- wbStall=1 with 5 ALU results offered (depth 4) -> 4 accepted, aluReady=0 on the 5th. Release wbStall -> 4 writes in order, then the 5th is accepted; pendingMask tracks throughout.
- Two enqueues to reg 0 (0xA then 0xB) with wbStall=1 -> pendingMask[0]=1 until the second write. Writes occur 0xA then 0xB, never reordered.
- Continuous back-to-back traffic for 20 cycles with simultaneous enqueue/dequeue -> count stays 1, the pointer wraps past depth, and no entry is lost or duplicated (scoreboarded against a reference queue).
- Assert reset low mid-traffic with 3 entries queued -> immediately regWrEn=0, pendingMask=0, fifoEmpty=1. After release, no stale write appears.
